// File: rtl/knapsack_search_ctrl.sv
// Purpose: exhaustive multi-constraint knapsack search over N_ITEMS items, keeping the best feasible subset and a feasible count.
// Latency: done pulses 2^N_ITEMS+3 cycles after the start-accept edge; one candidate subset per clock through a 2-stage pipeline.
// Backpressure: none; start is ignored while busy, abort cancels a running search without touching the published results.
module knapsack_search_ctrl #(
    parameter int N_ITEMS = 5,
    parameter int W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_idx,
    input  logic [W-1:0]       cfg_value,
    input  logic [W-1:0]       cfg_weight,
    input  logic [W-1:0]       cfg_volume,
    input  logic [W-1:0]       min_value,
    input  logic [W-1:0]       max_weight,
    input  logic [W-1:0]       max_volume,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [N_ITEMS-1:0] best_mask,
    output logic [W+2:0]       best_value,
    output logic [N_ITEMS:0]   feas_count
);

    localparam int SUM_W = W + 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    // item table
    logic [W-1:0] item_val [N_ITEMS];
    logic [W-1:0] item_wgt [N_ITEMS];
    logic [W-1:0] item_vol [N_ITEMS];

    // limits frozen at start acceptance
    logic [W-1:0] lim_min;
    logic [W-1:0] lim_wgt;
    logic [W-1:0] lim_vol;

    // sequencing
    logic [N_ITEMS-1:0] cnt;
    logic               drain_cnt;
    logic               start_acc;

    // stage-1 registers
    logic               s1_vld;
    logic [N_ITEMS-1:0] s1_mask;
    logic [SUM_W-1:0]   s1_val;
    logic [SUM_W-1:0]   s1_wgt;
    logic [SUM_W-1:0]   s1_vol;

    // stage-2 running results
    logic               run_found;
    logic [N_ITEMS-1:0] run_mask;
    logic [SUM_W-1:0]   run_value;
    logic [N_ITEMS:0]   run_count;

    // combinational sums for the mask being issued
    logic [SUM_W-1:0]   sum_val;
    logic [SUM_W-1:0]   sum_wgt;
    logic [SUM_W-1:0]   sum_vol;
    logic               feas;

    assign start_acc = (state == IDLE) && start && !abort;

    // Item table writes, only accepted while idle; out-of-range indices fall through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                item_val[i] <= '0;
                item_wgt[i] <= '0;
                item_vol[i] <= '0;
            end
        end else if (cfg_we && (state == IDLE)) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                if (cfg_idx == 3'(i)) begin
                    item_val[i] <= cfg_value;
                    item_wgt[i] <= cfg_weight;
                    item_vol[i] <= cfg_volume;
                end
            end
        end
    end

    // Zero-extended totals of the currently issued subset.
    always_comb begin
        sum_val = '0;
        sum_wgt = '0;
        sum_vol = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (cnt[i]) begin
                sum_val = sum_val + {3'b000, item_val[i]};
                sum_wgt = sum_wgt + {3'b000, item_wgt[i]};
                sum_vol = sum_vol + {3'b000, item_vol[i]};
            end
        end
    end

    // Feasibility of the subset held in stage 1.
    always_comb begin
        feas = (s1_val >= {3'b000, lim_min}) &&
               (s1_wgt <= {3'b000, lim_wgt}) &&
               (s1_vol <= {3'b000, lim_vol});
    end

    // Two-stage pipeline: stage 1 latches totals, stage 2 folds them into the running best/count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_mask   <= '0;
            s1_val    <= '0;
            s1_wgt    <= '0;
            s1_vol    <= '0;
            run_found <= 1'b0;
            run_mask  <= '0;
            run_value <= '0;
            run_count <= '0;
        end else begin
            s1_vld <= (state == RUN) && !abort;
            if (state == RUN) begin
                s1_mask <= cnt;
                s1_val  <= sum_val;
                s1_wgt  <= sum_wgt;
                s1_vol  <= sum_vol;
            end
            if (start_acc) begin
                run_found <= 1'b0;
                run_mask  <= '0;
                run_value <= '0;
                run_count <= '0;
            end else if (s1_vld && (state != IDLE) && feas) begin
                run_count <= run_count + 1'b1;
                // strict compare keeps the lower mask on ties
                if (!run_found || (s1_val > run_value)) begin
                    run_found <= 1'b1;
                    run_mask  <= s1_mask;
                    run_value <= s1_val;
                end
            end
        end
    end

    // Search sequencer with registered status and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            drain_cnt  <= 1'b0;
            lim_min    <= '0;
            lim_wgt    <= '0;
            lim_vol    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            best_mask  <= '0;
            best_value <= '0;
            feas_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        lim_min <= min_value;
                        lim_wgt <= max_weight;
                        lim_vol <= max_volume;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == '1) begin
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (drain_cnt) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (!abort) begin
                        done       <= 1'b1;
                        found      <= run_found;
                        best_mask  <= run_mask;
                        best_value <= run_value;
                        feas_count <= run_count;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knapsack_search_ctrl.sv
// Purpose: scoreboard bench for knapsack_search_ctrl; directed plan cases plus randomized tables against a brute-force model.
// Latency: expects done exactly 2^N+3 cycles after the start-accept edge.
// Backpressure: n/a; checks that start/cfg_we are ignored while busy and that abort suppresses done.
module tb_knapsack_search_ctrl;

    localparam int N = 5;
    localparam int W = 16;

    logic           clk;
    logic           rst_n;
    logic           cfg_we;
    logic [2:0]     cfg_idx;
    logic [W-1:0]   cfg_value;
    logic [W-1:0]   cfg_weight;
    logic [W-1:0]   cfg_volume;
    logic [W-1:0]   min_value;
    logic [W-1:0]   max_weight;
    logic [W-1:0]   max_volume;
    logic           start;
    logic           abort;
    logic           busy;
    logic           done;
    logic           found;
    logic [N-1:0]   best_mask;
    logic [W+2:0]   best_value;
    logic [N:0]     feas_count;

    knapsack_search_ctrl #(.N_ITEMS(N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_value  (cfg_value),
        .cfg_weight (cfg_weight),
        .cfg_volume (cfg_volume),
        .min_value  (min_value),
        .max_weight (max_weight),
        .max_volume (max_volume),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .best_mask  (best_mask),
        .best_value (best_value),
        .feas_count (feas_count)
    );

    typedef struct {
        bit     found;
        longint mask;
        longint value;
        longint count;
        int     dcyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int tv[N];
    int tw[N];
    int tm[N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Brute force over every subset in ascending mask order.
    task automatic model(input int minv, input int maxw, input int maxv, output exp_t e);
        e.found = 0; e.mask = 0; e.value = 0; e.count = 0; e.dcyc = 0;
        for (int m = 0; m < (1 << N); m++) begin
            int sv, sw, sm;
            sv = 0; sw = 0; sm = 0;
            for (int i = 0; i < N; i++) begin
                if (((m >> i) & 1) == 1) begin
                    sv += tv[i]; sw += tw[i]; sm += tm[i];
                end
            end
            if (sv >= minv && sw <= maxw && sm <= maxv) begin
                e.count++;
                if (!e.found || sv > e.value) begin
                    e.found = 1; e.mask = m; e.value = sv;
                end
            end
        end
    endtask

    task automatic push_exp(input bit f, input longint m, input longint v, input longint c, input int acc);
        exp_t e;
        e.found = f; e.mask = m; e.value = v; e.count = c;
        e.dcyc = acc + (1 << N) + 3;
        sbq.push_back(e);
    endtask

    task automatic write_item(input int idx, input int v, input int w, input int m);
        @(negedge clk);
        cfg_we     = 1'b1;
        cfg_idx    = idx[2:0];
        cfg_value  = v[W-1:0];
        cfg_weight = w[W-1:0];
        cfg_volume = m[W-1:0];
        @(negedge clk);
        cfg_we = 1'b0;
        if (idx < N) begin
            tv[idx] = v & 32'hffff;
            tw[idx] = w & 32'hffff;
            tm[idx] = m & 32'hffff;
        end
    endtask

    // Pulse start; acc is the cycle count just after the accept edge. Limits are scrambled afterwards.
    task automatic launch(input int minv, input int maxw, input int maxv, input bit use_model, output int acc);
        exp_t e;
        @(negedge clk);
        min_value  = minv[W-1:0];
        max_weight = maxw[W-1:0];
        max_volume = maxv[W-1:0];
        start      = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        check("busy_after_start", longint'(busy), 1);
        @(negedge clk);
        start      = 1'b0;
        min_value  = W'($urandom);
        max_weight = W'($urandom);
        max_volume = W'($urandom);
        if (use_model) begin
            model(minv, maxw, maxv, e);
            push_exp(e.found, e.mask, e.value, e.count, acc);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            check("done_timeout", longint'(sbq.size()), 0);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_outputs(input string tag, input bit f, input longint m, input longint v, input longint c);
        check({tag, "_found"}, longint'(found), longint'(f));
        check({tag, "_mask"},  longint'(best_mask), m);
        check({tag, "_value"}, longint'(best_value), v);
        check({tag, "_count"}, longint'(feas_count), c);
    endtask

    task automatic load_plan1();
        write_item(0, 4, 12, 1);
        write_item(1, 2, 1, 1);
        write_item(2, 2, 2, 1);
        write_item(3, 1, 1, 1);
        write_item(4, 10, 4, 1);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", longint'(done), 0);
            end else begin
                mon_e = sbq.pop_front();
                check("done_latency", longint'(cyc), longint'(mon_e.dcyc));
                check_outputs("res", mon_e.found, mon_e.mask, mon_e.value, mon_e.count);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_value = '0; cfg_weight = '0; cfg_volume = '0;
        min_value = '0; max_weight = '0; max_volume = '0;
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < N; i++) begin tv[i] = 0; tw[i] = 0; tm[i] = 0; end
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check_outputs("rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // plan case 1: single feasible subset 0x1E
        load_plan1();
        launch(15, 16, 10, 0, acc);
        push_exp(1, 'h1E, 15, 1, acc);
        wait_drain();

        // plan case 2: nothing feasible
        launch(16, 16, 10, 0, acc);
        push_exp(0, 0, 0, 0, acc);
        wait_drain();

        // plan case 3: value tie keeps the lower mask
        write_item(0, 5, 10, 1);
        write_item(1, 5, 10, 1);
        write_item(2, 1, 20, 1);
        write_item(3, 1, 20, 1);
        write_item(4, 1, 20, 1);
        launch(1, 10, 100, 0, acc);
        push_exp(1, 'h01, 5, 2, acc);
        wait_drain();

        // abort: results of the prior search survive, no done, busy-time writes/starts ignored
        load_plan1();
        launch(15, 16, 10, 0, acc);
        push_exp(1, 'h1E, 15, 1, acc);
        wait_drain();
        launch(16, 16, 10, 0, acc);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            cfg_we     = 1'b1;
            cfg_idx    = 3'($urandom_range(0, N - 1));
            cfg_value  = W'($urandom);
            cfg_weight = W'($urandom);
            cfg_volume = W'($urandom);
            start      = k[0];
        end
        @(negedge clk);
        cfg_we = 1'b0;
        start  = 1'b0;
        abort  = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_abort", longint'(busy), 0);
        @(negedge clk);
        abort = 1'b0;
        repeat (45) @(negedge clk);
        check_outputs("hold", 1, 'h1E, 15, 1);
        launch(15, 16, 10, 0, acc);
        push_exp(1, 'h1E, 15, 1, acc);
        wait_drain();

        // start together with abort in idle is ignored
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("busy_start_abort", longint'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (40) @(negedge clk);

        // randomized tables and limits, including dropped out-of-range writes
        for (int it = 0; it < 8; it++) begin
            int minv, maxw, maxv;
            for (int i = 0; i < N; i++) begin
                if (it[0])
                    write_item(i, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                               int'($urandom_range(0, 65535)));
                else
                    write_item(i, int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                               int'($urandom_range(0, 40)));
            end
            write_item(int'($urandom_range(N, 7)), int'($urandom_range(0, 65535)), 0, 0);
            if (it[0]) begin
                minv = int'($urandom_range(0, 65535));
                maxw = int'($urandom_range(0, 65535));
                maxv = int'($urandom_range(0, 65535));
            end else begin
                minv = int'($urandom_range(0, 80));
                maxw = int'($urandom_range(0, 100));
                maxv = int'($urandom_range(0, 100));
            end
            launch(minv, maxw, maxv, 1, acc);
            wait_drain();
        end

        // asynchronous reset mid-search clears everything at once
        launch(0, 100, 100, 0, acc);
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", longint'(busy), 0);
        check("arst_done", longint'(done), 0);
        check_outputs("arst", 0, 0, 0, 0);
        for (int i = 0; i < N; i++) begin tv[i] = 0; tw[i] = 0; tm[i] = 0; end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(0, 0, 0, 0, acc);
        push_exp(1, 0, 0, 32, acc);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/knapsack_search_ctrl.md
Name: knapsack_search_ctrl

Overview:
- Sequencer that finds the best subset for a multi-constraint (value/weight/volume) knapsack over N items by exhaustive enumeration.
- Holds a programmable item table and a limit set, and evaluates one candidate subset per clock through a 2-stage pipeline.
- Reports the highest-value feasible subset and the number of feasible subsets.
- Sits between the host configuration interface and downstream consumers of the selection mask.

Parameters:
- N_ITEMS, 5, number of items (1..8); subset mask width.
- W, 16, width of each per-item value/weight/volume and of each limit.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  item-table write strobe.
- cfg_idx  in  3  item index to write; writes with cfg_idx >= N_ITEMS are dropped.
- cfg_value  in  W  item value.
- cfg_weight  in  W  item weight.
- cfg_volume  in  W  item volume.
- min_value  in  W  feasibility: total value >= min_value.
- max_weight  in  W  feasibility: total weight <= max_weight.
- max_volume  in  W  feasibility: total volume <= max_volume.
- start  in  1  begin a search (pulse).
- abort  in  1  cancel a running search.
- busy  out  1  high while a search is in progress.
- done  out  1  one-cycle pulse when results are updated.
- found  out  1  at least one feasible subset existed.
- best_mask  out  N_ITEMS  selection of the best subset; bit i set means item i is selected.
- best_value  out  W+3  total value of best_mask.
- feas_count  out  N_ITEMS+1  number of feasible subsets.

Behaviour:
- Reset:
  - Every output is 0.
  - Item table is cleared to 0.
  - State is IDLE.
  - Asserting rst_n low mid-search takes effect immediately and discards the search.
- Sums are SUM_W = W+3 bits, zero-extended, unsigned; they cannot overflow for N_ITEMS <= 8. Comparisons are unsigned at SUM_W.
- Item table:
  - A write occurs on clk when cfg_we=1 and state is IDLE.
  - cfg_we is ignored while busy.
- Limits are captured into internal registers on start acceptance; later changes on those inputs have no effect on the running search.
- States:
  - IDLE:
    - start=1 (and abort=0) is accepted.
    - Captures the limits, clears mask counter, running best and running count.
    - Moves to RUN; busy goes high the next cycle.
  - RUN:
    - Mask counter issues subsets 0 .. 2^N_ITEMS-1, one per cycle, into the pipeline.
    - After issuing the last subset, moves to DRAIN.
  - DRAIN:
    - Waits 2 cycles for the pipeline to empty.
    - Then moves to DONE.
  - DONE:
    - Copies the running results to the outputs.
    - Pulses done for 1 cycle, drops busy, and returns to IDLE.
- Pipeline:
  - Stage 1 registers total value, total weight and total volume for the issued mask, together with the mask.
  - Stage 2 evaluates feasibility and updates the running best and running count.
- Best update rule:
  - Feasible and (no best yet, or value strictly greater than running best).
  - Ties keep the earlier, numerically lower mask.
  - The empty mask is a legal candidate; it is feasible when min_value=0.
- Latency: done asserts exactly 2^N_ITEMS+3 cycles after the start-accept edge.
- start while busy: ignored.
- abort while busy:
  - Returns to IDLE on the next edge with busy=0.
  - No done pulse.
  - Outputs keep their values from the previous completed search.
- start and abort both high in IDLE: start is ignored.
- No feasible subset: found=0, best_mask=0, best_value=0, feas_count=0.

Test Plan:
- Load values {4,2,2,1,10}, weights {12,1,2,1,4}, volumes {1,1,1,1,1}; min_value=15, max_weight=16, max_volume=10; start -> done at start+35 with found=1, best_mask=0x1E, best_value=15, feas_count=1.
- Same table, min_value=16 -> done pulses with found=0, best_mask=0, best_value=0, feas_count=0.
- Items 0 and 1 = value 5, weight 10; items 2..4 = value 1, weight 20; volumes 1; min_value=1, max_weight=10 -> best_mask=0x01 (tie keeps the lower mask), best_value=5, feas_count=2.
- Run test 1, then start test 2 and assert abort 10 cycles in -> busy drops the next cycle, no done pulse, outputs still hold test-1 results; cfg_we and start pulses issued during the run have no effect (table readback via a fresh search matches the pre-run table).
- rst_n low at cycle 20 of a search -> busy, done, found, best_mask, best_value and feas_count are 0 immediately; a start after reset release with an empty table and min_value=0 -> feas_count=32, best_mask=0, best_value=0, found=1.
